instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder side of the instruction-format protocol: packs (format, registers, opcode, immediate) fields into
//  32-bit instruction words and writes them sequentially into instruction memory.
//  Sits between the program loader/testbench host and the instruction RAM that the fetch/decode stage reads.
//  Illegal field combinations are written as NOP and flagged.
// PARAMETERS
//  ADDR_W  8            instruction memory address width
//  DEPTH   2**ADDR_W    number of words writable; the last address is DEPTH-1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       pulse: clear address counter/flags, enter LOAD
//  in_valid     in   1       field beat valid
//  in_ready     out  1       block can accept a beat
//  in_last      in   1       final instruction of the program
//  in_format    in   2       0=(a) R-R-R, 1=(b) R-R-imm16, 2=(c) imm26, 3=illegal
//  in_rsrc1     in   5       source register 1 (a,b)
//  in_rsrc2     in   5       source register 2 (a)
//  in_rdst      in   5       destination register (a,b)
//  in_opcode    in   17      (a) uses [16:0]; (b)/(c) use [5:0]
//  in_imm       in   26      (b) uses [15:0]; (c) uses [25:0]
//  mem_we       out  1       instruction RAM write strobe
//  mem_addr     out  ADDR_W  write address
//  mem_wdata    out  32      encoded instruction word
//  busy         out  1       state != IDLE && state != DONE
//  done         out  1       high while in DONE
//  err_illegal  out  1       sticky: at least one beat was replaced by NOP
//  err_overflow out  1       sticky: a beat was offered after the memory was full
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, both err flags=0.
//  Encoding: (a) {rsrc1,rsrc2,rdst,opcode[16:0]}; (b) {rsrc1,rdst,imm[15:0],opcode[5:0]};
//    (c) {imm[25:0],opcode[5:0]}. Unused input bits are ignored.
//  Legality: (a) requires opcode[5:0]==6'b000000; (b) requires opcode[5:0] to be 6'b100010 or 6'b100011.
//    (c) requires opcode[5:0] to be none of 000000/100010/100011; format 3 is always illegal.
//    Illegal beat: write NOP 32'h0000003F, set err_illegal.
//  Handshake: a beat is accepted when in_valid && in_ready. mem_we pulses exactly 1 cycle later with the
//    registered word (1-cycle latency). mem_addr increments after each write.
//  FSM:
//    IDLE -start-> LOAD (addr counter=0, err flags cleared).
//    LOAD: in_ready=1. Accepting the beat at addr DEPTH-1, or any beat with in_last=1 -> FINISH.
//    FINISH -> PAD (if enabled and addr<DEPTH-1 after final write) else -> DONE.
//    DONE: in_ready=0. in_valid in DONE after a full-memory finish sets err_overflow.
//    start in DONE or IDLE re-enters LOAD.
//  Address wrap: never wraps; the counter saturates at DEPTH-1 and the full condition ends the load.
//  start while busy: ignored. rst_n low mid-operation: immediate return to reset values, in-flight write dropped.
//  Simultaneous in_last and memory-full on the same beat: normal finish, no overflow.
// CONFIGURATION
//  INSTR_LOADER_NOP_PAD_EN defined:
//    PAD writes 32'h0000003F to every address after the last program word through DEPTH-1, one per cycle,
//    with in_ready=0; then -> DONE.
//  Not defined: PAD state is absent; FINISH -> DONE; unwritten words are left untouched.
// STRUCTURE
//  Shared package: format codes FMT_A/FMT_B/FMT_C, opcodes OP_FMT_A=6'b000000, OP_B0=6'b100010,
//    OP_B1=6'b100011, NOP_WORD=32'h0000003F, and field bit-position constants (shared with the decoder).
//  One sub-module: instr_field_packer (combinational pack + legality check); the FSM, counter and output
//    register live in the top.
// TESTING
//  1. start; fmt a, rsrc1=1, rsrc2=2, rdst=3, opcode=0, last -> next cycle mem_we=1, addr=0,
//     wdata=32'h08860000, then done=1.
//  2. fmt b, rsrc1=4, rdst=5, imm=16'h1234, opcode=6'h22 -> wdata=32'h21448D22, err_illegal=0.
//  3. fmt c, imm=26'h3FFFFFF, opcode=6'h3E -> wdata=32'hFFFFFFFE. Then fmt b with opcode=6'h05 ->
//     wdata=32'h0000003F, err_illegal=1.
//  4. ADDR_W=2: 4 beats with no last -> addrs 0..3 written, done=1; 5th in_valid -> err_overflow=1,
//     no mem_we.
//  5. rst_n low during LOAD, 1 cycle after an accepted beat -> no mem_we, all outputs at reset values.
//  6. NOP_PAD_EN, ADDR_W=3, 2 beats with last on the 2nd -> addrs 2..7 written with 32'h0000003F,
//     then done=1.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-format definitions: format codes, special opcodes, NOP word and field positions.
package instr_encoder_loader_pkg;

    typedef enum logic [1:0] {
        FMT_A   = 2'd0,
        FMT_B   = 2'd1,
        FMT_C   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    localparam logic [5:0]  OP_FMT_A = 6'b000000;
    localparam logic [5:0]  OP_B0    = 6'b100010;
    localparam logic [5:0]  OP_B1    = 6'b100011;
    localparam logic [31:0] NOP_WORD = 32'h0000003F;

    // Field LSB positions inside the 32-bit word, shared with the decoder.
    localparam int unsigned RSRC1_LSB  = 27;
    localparam int unsigned RSRC2_LSB  = 22;
    localparam int unsigned RDST_A_LSB = 17;
    localparam int unsigned RDST_B_LSB = 22;
    localparam int unsigned IMM_LSB    = 6;
    localparam int unsigned OPC_LSB    = 0;

    // Opcodes that select format (a) or (b) and so cannot appear as a format (c) opcode.
    function automatic logic is_reserved_op(input logic [5:0] op);
        return (op == OP_FMT_A) || (op == OP_B0) || (op == OP_B1);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational field packer: builds the 32-bit instruction word and flags illegal combinations.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]  format,
    input  logic [4:0]  rsrc1,
    input  logic [4:0]  rsrc2,
    input  logic [4:0]  rdst,
    input  logic [16:0] opcode,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [31:0] raw;

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (fmt_e'(format))
            FMT_A: begin
                raw[RSRC1_LSB +: 5]  = rsrc1;
                raw[RSRC2_LSB +: 5]  = rsrc2;
                raw[RDST_A_LSB +: 5] = rdst;
                raw[OPC_LSB +: 17]   = opcode;
                illegal              = (opcode[5:0] != OP_FMT_A);
            end
            FMT_B: begin
                raw[RSRC1_LSB +: 5]  = rsrc1;
                raw[RDST_B_LSB +: 5] = rdst;
                raw[IMM_LSB +: 16]   = imm[15:0];
                raw[OPC_LSB +: 6]    = opcode[5:0];
                illegal              = !((opcode[5:0] == OP_B0) || (opcode[5:0] == OP_B1));
            end
            FMT_C: begin
                raw[IMM_LSB +: 26] = imm;
                raw[OPC_LSB +: 6]  = opcode[5:0];
                illegal            = is_reserved_op(opcode[5:0]);
            end
            default: illegal = 1'b1;
        endcase
        word = illegal ? NOP_WORD : raw;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads packed instruction words sequentially into instruction RAM with a 1-cycle write latency.
// Define INSTR_LOADER_NOP_PAD_EN to fill the unwritten tail of memory with NOP words after a load.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_format,
    input  logic [4:0]        in_rsrc1,
    input  logic [4:0]        in_rsrc2,
    input  logic [4:0]        in_rdst,
    input  logic [16:0]       in_opcode,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFinish,
        StDone
`ifdef INSTR_LOADER_NOP_PAD_EN
        , StPad
`endif
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              full_q;
    logic [31:0]       packed_word;
    logic              packed_illegal;

    instr_field_packer u_packer (
        .format  (in_format),
        .rsrc1   (in_rsrc1),
        .rsrc2   (in_rsrc2),
        .rdst    (in_rdst),
        .opcode  (in_opcode),
        .imm     (in_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    assign in_ready = (state_q == StLoad);
    assign done     = (state_q == StDone);
    assign busy     = (state_q != StIdle) && (state_q != StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            full_q       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= StLoad;
                        addr_q       <= '0;
                        full_q       <= 1'b0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end else if ((state_q == StDone) && in_valid && full_q) begin
                        err_overflow <= 1'b1;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= packed_word;
                        if (packed_illegal) begin
                            err_illegal <= 1'b1;
                        end
                        // Counter saturates; a full finish only counts as such without in_last.
                        if (addr_q == LAST_ADDR) begin
                            full_q  <= !in_last;
                            state_q <= StFinish;
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;
                            if (in_last) begin
                                state_q <= StFinish;
                            end
                        end
                    end
                end
                StFinish: begin
`ifdef INSTR_LOADER_NOP_PAD_EN
                    state_q <= (mem_addr != LAST_ADDR) ? StPad : StDone;
`else
                    state_q <= StDone;
`endif
                end
`ifdef INSTR_LOADER_NOP_PAD_EN
                StPad: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= NOP_WORD;
                    if (addr_q == LAST_ADDR) begin
                        state_q <= StDone;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
